// File: rtl/sram_wrapper_pkg.sv
// Shared types and helpers for the banked SRAM power wrapper.
//   pwr_state_e : per-bank power state
//   cnt_width() : width of a down-counter that holds values 0..delay-1
package sram_wrapper_pkg;

  typedef enum logic [2:0] {
    PWR_ON,
    PWR_RET,
    PWR_GATING,
    PWR_OFF,
    PWR_WAKING
  } pwr_state_e;

  // A delay of 1 still needs a one-bit counter register.
  function automatic int unsigned cnt_width(input int unsigned delay);
    return (delay > 1) ? $clog2(delay) : 1;
  endfunction

endpackage

// File: rtl/sram_bank_pwr_fsm.sv
// Per-bank power controller: ON / RET / GATING / OFF / WAKING.
//   clk_i, rst_ni     : clock, async active-low reset (bank comes up ON)
//   pwrgate_ni        : 0 requests power-gating of the bank
//   set_retentive_ni  : 0 requests retention (ignored while gating is requested)
//   state_o           : current power state, access is allowed only in PWR_ON
//   pwrgate_ack_no    : 0 once the bank is fully off, registered
module sram_bank_pwr_fsm
  import sram_wrapper_pkg::*;
#(
  parameter int unsigned PwrAckDelay = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pwrgate_ni,
  input  logic       set_retentive_ni,
  output pwr_state_e state_o,
  output logic       pwrgate_ack_no
);

  localparam int unsigned     CntW    = cnt_width(PwrAckDelay);
  localparam logic [CntW-1:0] CntInit = CntW'(PwrAckDelay - 1);

  pwr_state_e      r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_ack_n;

  // GATING and WAKING run to completion; the request level is only looked at
  // again once OFF or ON is reached, so a mid-sequence toggle cannot abort.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= PWR_ON;
      r_cnt   <= '0;
      r_ack_n <= 1'b1;
    end else begin
      unique case (r_state)
        PWR_ON: begin
          if (!pwrgate_ni) begin
            r_state <= PWR_GATING;
            r_cnt   <= CntInit;
          end else if (!set_retentive_ni) begin
            r_state <= PWR_RET;
          end
        end
        PWR_RET: begin
          if (!pwrgate_ni) begin
            r_state <= PWR_GATING;
            r_cnt   <= CntInit;
          end else if (set_retentive_ni) begin
            r_state <= PWR_ON;
          end
        end
        PWR_GATING: begin
          if (r_cnt == '0) begin
            r_state <= PWR_OFF;
            r_ack_n <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PWR_OFF: begin
          if (pwrgate_ni) begin
            r_state <= PWR_WAKING;
            r_cnt   <= CntInit;
          end
        end
        PWR_WAKING: begin
          if (r_cnt == '0) begin
            r_state <= PWR_ON;
            r_ack_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= PWR_ON;
          r_ack_n <= 1'b1;
        end
      endcase
    end
  end

  assign state_o        = r_state;
  assign pwrgate_ack_no = r_ack_n;

endmodule

// File: rtl/tc_sram.sv
// Behavioural single-cycle-latency SRAM macro model (byte-wide write enables).
//   clk_i, rst_ni : clock, async active-low reset (read register only)
//   req_i, we_i   : per-port request / write enable
//   addr_i        : per-port word address
//   wdata_i, be_i : per-port write data and byte enables
//   rdata_o       : per-port read data, valid the cycle after a read request
module tc_sram #(
  parameter  int unsigned NumWords  = 1024,
  parameter  int unsigned DataWidth = 32,
  parameter  int unsigned NumPorts  = 1,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned BeWidth   = DataWidth / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  logic [DataWidth-1:0]               r_mem [NumWords];
  logic [NumPorts-1:0][DataWidth-1:0] r_rdata;

  // NOTE: the storage array has no reset; clearing a RAM needs a write port per
  // word and would not map onto a macro. Only the read register is reset.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      for (int i = 0; i < BeWidth; i++) begin
        if (req_i[p] && we_i[p] && be_i[p][i]) begin
          r_mem[addr_i[p]][i*8 +: 8] <= wdata_i[p][i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (req_i[p] && !we_i[p]) begin
          r_rdata[p] <= r_mem[addr_i[p]];
        end
      end
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/sram_banked_pwr_wrapper.sv
// Multi-bank single-port SRAM wrapper with per-bank power gating / retention.
//   clk_i, rst_ni         : clock, async active-low reset
//   req_i, gnt_o          : request / combinational grant (bank must be ON)
//   we_i, addr_i          : write enable, word address (MSBs select the bank)
//   wdata_i, be_i         : write data and byte enables
//   rvalid_o, rdata_o     : read response one cycle after a granted read
//   pwrgate_ni            : per-bank gate request (0 = gate)
//   pwrgate_ack_no        : per-bank ack (0 = bank is off)
//   set_retentive_ni      : per-bank retention request (0 = retain)
module sram_banked_pwr_wrapper
  import sram_wrapper_pkg::*;
#(
  parameter  int unsigned NumBanks    = 4,
  parameter  int unsigned NumWords    = 1024,
  parameter  int unsigned DataWidth   = 32,
  parameter  int unsigned PwrAckDelay = 4,
  localparam int unsigned BankSel     = (NumBanks > 1) ? $clog2(NumBanks) : 0,
  localparam int unsigned WordAddrW   = $clog2(NumWords),
  localparam int unsigned AddrWidth   = WordAddrW + BankSel,
  localparam int unsigned BeWidth     = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  input  logic [NumBanks-1:0]  pwrgate_ni,
  output logic [NumBanks-1:0]  pwrgate_ack_no,
  input  logic [NumBanks-1:0]  set_retentive_ni
);

  // A single-bank build still needs a one-bit select signal to index with.
  localparam int unsigned BankSelW = (BankSel > 0) ? BankSel : 1;

  logic [BankSelW-1:0]  w_bank;
  logic [BankSelW-1:0]  r_bank;
  logic [WordAddrW-1:0] w_word_addr;
  pwr_state_e           w_state [NumBanks];
  logic [NumBanks-1:0]  w_bank_req;
  logic [DataWidth-1:0] w_rdata [NumBanks];
  logic                 r_rvalid;

  assign w_word_addr = addr_i[WordAddrW-1:0];

  if (NumBanks > 1) begin : g_bank_decode
    assign w_bank = addr_i[AddrWidth-1 -: BankSelW];
  end else begin : g_single_bank
    assign w_bank = '0;
  end

  assign gnt_o = req_i && (w_state[w_bank] == PWR_ON);

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    sram_bank_pwr_fsm #(
      .PwrAckDelay (PwrAckDelay)
    ) u_fsm (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .pwrgate_ni       (pwrgate_ni[b]),
      .set_retentive_ni (set_retentive_ni[b]),
      .state_o          (w_state[b]),
      .pwrgate_ack_no   (pwrgate_ack_no[b])
    );

    // Only the addressed bank sees a request, and only once it is granted.
    assign w_bank_req[b] = gnt_o && (w_bank == BankSelW'(b));

    tc_sram #(
      .NumWords  (NumWords),
      .DataWidth (DataWidth),
      .NumPorts  (1)
    ) u_sram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (w_bank_req[b]),
      .we_i    (we_i),
      .addr_i  (w_word_addr),
      .wdata_i (wdata_i),
      .be_i    (be_i),
      .rdata_o (w_rdata[b])
    );
  end

  // The bank that answered is remembered so the response still comes from it
  // even if the requester moves on to another bank in the next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_bank   <= '0;
    end else begin
      r_rvalid <= gnt_o && !we_i;
      if (gnt_o && !we_i) begin
        r_bank <= w_bank;
      end
    end
  end

  // NOTE: the default assignment first keeps this block latch-free.
  always_comb begin
    rdata_o = '0;
    if (r_rvalid) begin
      rdata_o = w_rdata[r_bank];
    end
  end

  assign rvalid_o = r_rvalid;

endmodule

// File: tb/tb_sram_banked_pwr_wrapper.sv
// Directed bench for sram_banked_pwr_wrapper (4 banks x 1024 words x 32 bits,
// power-ack delay 4). Table of access vectors plus hand-written power sequences.
module tb_sram_banked_pwr_wrapper;
  import sram_wrapper_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i;
  logic          gnt_o;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [BW-1:0] be_i;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic [NB-1:0] pwrgate_ni;
  logic [NB-1:0] pwrgate_ack_no;
  logic [NB-1:0] set_retentive_ni;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  sram_banked_pwr_wrapper #(
    .NumBanks    (NB),
    .NumWords    (1024),
    .DataWidth   (DW),
    .PwrAckDelay (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_i            (req_i),
    .gnt_o            (gnt_o),
    .we_i             (we_i),
    .addr_i           (addr_i),
    .wdata_i          (wdata_i),
    .be_i             (be_i),
    .rvalid_o         (rvalid_o),
    .rdata_o          (rdata_o),
    .pwrgate_ni       (pwrgate_ni),
    .pwrgate_ack_no   (pwrgate_ack_no),
    .set_retentive_ni (set_retentive_ni)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic          exp_gnt;
    logic          exp_rvalid;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    be_i    = be;
  endtask

  initial begin
    //            we    addr     wdata         be       gnt   rv    rdata
    vecs[0]  = '{1'b1, 12'h805, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 12'h805, 32'h0,        4'b0000, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 12'h010, 32'h11223344, 4'b1111, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 12'h010, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 12'h010, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 12'hC07, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 12'hC07, 32'h0,        4'b0000, 1'b1, 1'b1, 32'hCAFEF00D};
    vecs[7]  = '{1'b1, 12'h400, 32'h55AA55AA, 4'b1111, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 12'h400, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h55AA55AA};
    // Same word offset in bank 0 must not alias bank 2.
    vecs[9]  = '{1'b1, 12'h005, 32'h01020304, 4'b1111, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 12'h805, 32'h0,        4'b0000, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 12'h005, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h01020304};
    vecs[12] = '{1'b1, 12'hC07, 32'h99999999, 4'b0000, 1'b1, 1'b0, 32'h0};

    rst_ni           = 1'b0;
    req_i            = 1'b0;
    we_i             = 1'b0;
    addr_i           = '0;
    wdata_i          = '0;
    be_i             = '0;
    pwrgate_ni       = '1;
    set_retentive_ni = '1;

    // ---- reset state ----
    #12;
    check("reset_gnt",    32'(gnt_o),          32'h0);
    check("reset_rvalid", 32'(rvalid_o),       32'h0);
    check("reset_rdata",  rdata_o,             32'h0);
    check("reset_ack",    32'(pwrgate_ack_no), 32'hF);
    rst_ni = 1'b1;
    tick();

    // ---- table-driven accesses, all banks ON ----
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      #1;
      check($sformatf("vec%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].exp_gnt));
      tick();
      req_i = 1'b0;
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid_o), 32'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d_rdata", i),  rdata_o,       vecs[i].exp_rdata);
    end

    // ---- gate bank 1: ack falls exactly 4 edges after the request is seen ----
    pwrgate_ni[1] = 1'b0;
    tick();  // request sampled, bank 1 now GATING
    drive(1'b0, 12'h400, 32'h0, 4'b0);
    #1;
    check("gating_b1_gnt", 32'(gnt_o), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("gating_ack_hi_%0d", k), 32'(pwrgate_ack_no[1]), 32'h1);
      tick();
    end
    check("gating_ack_hi_4", 32'(pwrgate_ack_no[1]), 32'h1);
    tick();
    check("gated_ack_lo", 32'(pwrgate_ack_no), 32'hD);
    check("off_b1_gnt",   32'(gnt_o),          32'h0);
    // Bank 0 remains fully usable while bank 1 is off.
    drive(1'b0, 12'h010, 32'h0, 4'b0);
    #1;
    check("off_b0_gnt", 32'(gnt_o), 32'h1);
    tick();
    check("off_b0_rvalid", 32'(rvalid_o), 32'h1);
    check("off_b0_rdata",  rdata_o,       32'h11BB33DD);
    // Release; requester holds req to bank 1 until the grant appears.
    drive(1'b0, 12'h400, 32'h0, 4'b0);
    pwrgate_ni[1] = 1'b1;
    tick();  // WAKING
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("waking_ack_lo_%0d", k), 32'(pwrgate_ack_no[1]), 32'h0);
      check($sformatf("waking_gnt_%0d", k),    32'(gnt_o),             32'h0);
      tick();
    end
    check("waking_ack_lo_4", 32'(pwrgate_ack_no[1]), 32'h0);
    tick();
    check("woken_ack_hi", 32'(pwrgate_ack_no), 32'hF);
    check("woken_gnt",    32'(gnt_o),          32'h1);
    tick();
    req_i = 1'b0;
    check("woken_rvalid", 32'(rvalid_o), 32'h1);

    // ---- retention on bank 3 blocks access, preserves data ----
    set_retentive_ni[3] = 1'b0;
    tick();
    drive(1'b0, 12'hC07, 32'h0, 4'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("ret_gnt_%0d", k), 32'(gnt_o),             32'h0);
      check($sformatf("ret_ack_%0d", k), 32'(pwrgate_ack_no[3]), 32'h1);
      tick();
      check($sformatf("ret_rvalid_%0d", k), 32'(rvalid_o), 32'h0);
    end
    set_retentive_ni[3] = 1'b1;
    tick();
    check("ret_release_gnt", 32'(gnt_o), 32'h1);
    tick();
    req_i = 1'b0;
    check("ret_release_rvalid", 32'(rvalid_o), 32'h1);
    check("ret_release_rdata",  rdata_o,       32'hCAFEF00D);

    // ---- read granted in the same cycle pwrgate_ni[0] falls ----
    drive(1'b0, 12'h010, 32'h0, 4'b0);
    pwrgate_ni[0] = 1'b0;
    #1;
    check("samecyc_gnt", 32'(gnt_o), 32'h1);
    tick();
    req_i = 1'b0;
    check("samecyc_rvalid", 32'(rvalid_o),         32'h1);
    check("samecyc_rdata",  rdata_o,               32'h11BB33DD);
    check("samecyc_state",  32'(dut.w_state[0]),   32'(PWR_GATING));
    drive(1'b0, 12'h010, 32'h0, 4'b0);
    #1;
    check("samecyc_after_gnt", 32'(gnt_o), 32'h0);
    req_i = 1'b0;

    // ---- async reset mid-GATING with a pending rvalid ----
    drive(1'b0, 12'h805, 32'h0, 4'b0);
    tick();
    req_i = 1'b0;
    check("prerst_rvalid", 32'(rvalid_o),       32'h1);
    check("prerst_state",  32'(dut.w_state[0]), 32'(PWR_GATING));
    #2;
    rst_ni     = 1'b0;
    pwrgate_ni = '1;
    #1;
    check("midrst_rvalid", 32'(rvalid_o),         32'h0);
    check("midrst_rdata",  rdata_o,               32'h0);
    check("midrst_ack",    32'(pwrgate_ack_no),   32'hF);
    check("midrst_state",  32'(dut.w_state[0]),   32'(PWR_ON));
    #3;
    rst_ni = 1'b1;
    tick();
    drive(1'b0, 12'h010, 32'h0, 4'b0);
    #1;
    check("postrst_gnt", 32'(gnt_o), 32'h1);
    tick();
    req_i = 1'b0;
    check("postrst_rvalid", 32'(rvalid_o), 32'h1);
    check("postrst_rdata",  rdata_o,       32'h11BB33DD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
